ser_arb_ctrl: RTL

SER_ARB_CTRL -- requirements
Module: ser_arb_ctrl

---
 rtl/ser_pkg.sv | 14 +
 rtl/rr_arb2.sv | 34 +++
 rtl/ser_arb_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared types and default parameter values for the arbitrated serializer.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int N_DEF   = 8;
  localparam int DIV_DEF = 1;
  localparam int GAP_DEF = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter: combinational one-hot grant, pointer
// advances only when the granted request is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 means requester 1 won last, so requester 0 has priority on a tie.
  logic last_req1;

  // NOTE: combinational outputs get a default first so no path infers a latch.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_req1 ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_req1 <= 1'b1;
    end else if (accept) begin
      last_req1 <= grant[1];
    end
  end

endmodule

// File: rtl/ser_arb_ctrl.sv
// Arbitrates two word requesters and serializes the winning word MSB first,
// DIV clocks per bit, followed by GAP idle cycles.
module ser_arb_ctrl
  import ser_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int DIV = DIV_DEF,
  parameter int GAP = GAP_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_data,
  output logic         req1_ready,
  output logic         s_out,
  output logic         s_frame,
  output logic [1:0]   grant,
  output logic         done
);

  localparam int BW = $clog2(N + 1);
  localparam int DW = $clog2(DIV + 1);
  localparam int GW = $clog2(GAP + 1);

  state_t         state, state_next;
  logic [N-1:0]   shift_reg;
  logic [BW-1:0]  bit_cnt;
  logic [DW-1:0]  div_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [1:0]     owner;
  logic [1:0]     arb_grant;
  logic [1:0]     ready_vec;
  logic           accept;
  logic           div_last, bit_last, gap_last;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (arb_grant)
  );

  // Ready only in IDLE and never while reset is asserted.
  assign ready_vec  = (state == ST_IDLE && rst) ? arb_grant : 2'b00;
  assign accept     = |ready_vec;
  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  assign div_last = (div_cnt == DW'(DIV - 1));
  assign bit_last = (bit_cnt == BW'(N - 1));
  assign gap_last = (gap_cnt == GW'(GAP - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_SHIFT;
      ST_SHIFT: if (bit_last && div_last) state_next = ST_GAP;
      ST_GAP:   if (gap_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: the shift register is plain datapath, but it is still cleared on reset
  // so an aborted word can never leak onto s_out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      owner     <= 2'b00;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          div_cnt <= '0;
          gap_cnt <= '0;
          if (accept) begin
            shift_reg <= ready_vec[1] ? req1_data : req0_data;
            owner     <= ready_vec;
          end
        end
        ST_SHIFT: begin
          if (div_last) begin
            div_cnt   <= '0;
            shift_reg <= {shift_reg[N-2:0], 1'b0};
            bit_cnt   <= bit_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_GAP:  gap_cnt <= gap_cnt + 1'b1;
        default: gap_cnt <= '0;
      endcase
    end
  end

  assign s_frame = (state == ST_SHIFT);
  assign s_out   = s_frame & shift_reg[N-1];
  assign grant   = s_frame ? owner : 2'b00;
  assign done    = (state == ST_GAP) && (gap_cnt == '0);

endmodule
